vga_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VGA timing generator: consumes hsync/vsync/blank plus a 24-bit

---
 rtl/vga_sync_decoder.sv | 168 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers pixel_x/pixel_y, sync strobes and lock, flags timing errors.
// Latency 2 clk from input to outputs, no backpressure; define VGA_DEC_SUM_EN for the frame_sum checksum.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_ACT_LO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [23:0] pixel_in,
  output logic [23:0] pixel_out,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [2:0]  err,
  output logic [23:0] frame_sum
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs1_q, hs1_d, hs2_q, hs2_d, vs1_q, vs1_d, vs2_q, vs2_d, act1_q, act1_d;
  logic [23:0] pix1_q, pix1_d, pix_out_q, pix_out_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        valid_q, valid_d, ls_q, ls_d, fs_q, fs_d, locked_q, locked_d;
  logic [2:0]  err_q, err_d;
  logic        hs_edge, vs_edge, h_bad, v_bad, x_bad;
  logic [9:0]  v_meas, x_base;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  always_comb begin
    hs1_d   = (SYNC_ACT_LO != 0) ? ~hsync : hsync;
    vs1_d   = (SYNC_ACT_LO != 0) ? ~vsync : vsync;
    act1_d  = ~blank;
    pix1_d  = pixel_in;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    hs_edge = hs1_q & ~hs2_q;
    vs_edge = vs1_q & ~vs2_q;

    h_cnt_d = hs_edge ? 10'd0 : sat_inc(h_cnt_q);
    // line count for the frame includes an hsync edge coinciding with the closing vsync edge
    v_meas  = hs_edge ? sat_inc(v_cnt_q) : v_cnt_q;
    v_cnt_d = vs_edge ? 10'd0 : v_meas;
    x_base  = hs_edge ? 10'd0 : x_cnt_q;
    x_cnt_d = act1_q ? sat_inc(x_base) : x_base;
    y_cnt_d = y_cnt_q;
    if (vs_edge)
      y_cnt_d = 10'd0;
    else if (hs_edge && x_cnt_q != 10'd0)
      y_cnt_d = sat_inc(y_cnt_q);

    h_bad = hs_edge && (int'(h_cnt_q) + 1 != H_TOTAL);
    x_bad = hs_edge && (x_cnt_q != 10'd0) && (int'(x_cnt_q) != H_ACTIVE);
    v_bad = vs_edge && (int'(v_meas) != V_TOTAL);

    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      SEARCH: if (vs_edge) state_d = MEASURE;
      MEASURE, LOCKED: begin
        err_d = err_q | {x_bad, v_bad, h_bad};
        if (h_bad || v_bad || x_bad)
          state_d = SEARCH;
        else if (state_q == MEASURE && vs_edge)
          state_d = LOCKED;
      end
      default: state_d = SEARCH;
    endcase

    locked_d  = (state_d == LOCKED);
    valid_d   = act1_q && (state_d == LOCKED);
    pix_out_d = pix1_q;
    pix_x_d   = x_base;
    pix_y_d   = y_cnt_d;
    ls_d      = hs_edge;
    fs_d      = vs_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      hs1_q     <= 1'b0;
      hs2_q     <= 1'b0;
      vs1_q     <= 1'b0;
      vs2_q     <= 1'b0;
      act1_q    <= 1'b0;
      pix1_q    <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      pix_out_q <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      valid_q   <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      hs1_q     <= hs1_d;
      hs2_q     <= hs2_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      act1_q    <= act1_d;
      pix1_q    <= pix1_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      pix_out_q <= pix_out_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      valid_q   <= valid_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

`ifdef VGA_DEC_SUM_EN
  logic [23:0] acc_q, acc_d, sum_q, sum_d, acc_add;

  always_comb begin
    acc_add = acc_q + ((act1_q && state_q != SEARCH) ? pix1_q : 24'h0);
    acc_d   = vs_edge ? 24'h0 : acc_add;
    sum_d   = vs_edge ? acc_add : sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 24'h0;
`endif

  assign pixel_out   = pix_out_q;
  assign pixel_valid = valid_q;
  assign pixel_x     = pix_x_q;
  assign pixel_y     = pix_y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder with a 12x6 timing (8x4 active), active-low syncs.
module tb_vga_sync_decoder;
  logic        clk = 1'b0, rst = 1'b1, hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic [23:0] pixel_in = '0;
  logic [23:0] pixel_out, frame_sum;
  logic        pixel_valid, line_start, frame_start, locked;
  logic [9:0]  pixel_x, pixel_y;
  logic [2:0]  err;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, line_cyc = 0, mark_cyc = 0, vstart = 0;
  int lock_rise_cyc = -1, unlock_cyc = -1, fs_cyc = -1, vcnt = 0, k = 0;
  bit pix_one = 1'b0, mon_en = 1'b0, locked_prev = 1'b0, ls_at_unl = 1'b0, fs_at_unl = 1'b0;

  vga_sync_decoder #(.H_ACTIVE(8), .H_TOTAL(12), .V_TOTAL(6), .SYNC_ACT_LO(1)) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .blank(blank), .pixel_in(pixel_in),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start), .locked(locked), .err(err),
    .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: lock transitions, strobes and the active-pixel raster of the watched frame
  always @(negedge clk) begin
    if (locked && !locked_prev) lock_rise_cyc = cyc;
    if (!locked && locked_prev) begin
      unlock_cyc = cyc;
      ls_at_unl  = line_start;
      fs_at_unl  = frame_start;
    end
    locked_prev = locked;
    if (frame_start) begin
      fs_cyc = cyc;
      k = 0;
    end
    if (pixel_valid) begin
      vcnt++;
      if (mon_en) begin
        check_eq("pix_x", 64'(pixel_x), 64'(k % 8));
        check_eq("pix_y", 64'(pixel_y), 64'(k / 8));
        check_eq("pix_out", 64'(pixel_out), 64'({8'hA5, 8'(k / 8), 8'(k % 8)}));
        k++;
      end
    end
  end

  task automatic drive_line(input int ln, input int len, input int nact, input bit vs);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (i == 0) line_cyc = cyc;
      hsync = (i < 2) ? 1'b0 : 1'b1;
      vsync = (vs && i < 2) ? 1'b0 : 1'b1;
      if (i >= 4 && i < 4 + nact) begin
        blank    = 1'b0;
        pixel_in = pix_one ? 24'h1 : {8'hA5, 8'(ln - 1), 8'(i - 4)};
      end else begin
        blank    = 1'b1;
        pixel_in = '0;
      end
    end
  endtask

  // Line 0 carries vsync, lines 1..4 are active; long_l gets 13 clocks, short_l gets 7 pixels
  task automatic drive_frame(input int first, input int last, input int long_l,
                             input int short_l, input int mark_l);
    for (int l = first; l <= last; l++) begin
      drive_line(l, (l == long_l) ? 13 : 12,
                 (l >= 1 && l <= 4) ? ((l == short_l) ? 7 : 8) : 0, l == 0);
      if (l == mark_l) mark_cyc = line_cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_locked", 64'(locked), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_outs", 64'({pixel_out, pixel_valid, pixel_x, pixel_y, line_start, frame_start}), 64'd0);
    check_eq("rst_sum", 64'(frame_sum), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    drive_frame(0, 5, -1, -1, -1);
    drive_frame(0, 5, -1, -1, 0);
    @(negedge clk);
    check_eq("lock_latency", 64'(lock_rise_cyc), 64'(mark_cyc + 2));
    check_eq("fs_latency", 64'(fs_cyc), 64'(mark_cyc + 2));
    check_eq("locked_after_2", 64'(locked), 64'd1);

    vstart = vcnt;
    mon_en = 1'b1;
    drive_frame(0, 5, -1, -1, -1);
    mon_en = 1'b0;
    @(negedge clk);
    check_eq("valid_count", 64'(vcnt - vstart), 64'd32);
    check_eq("raster_count", 64'(k), 64'd32);
    check_eq("err_clean", 64'(err), 64'd0);

    drive_frame(0, 5, 2, -1, 3);
    @(negedge clk);
    check_eq("long_unlock_cyc", 64'(unlock_cyc), 64'(mark_cyc + 2));
    check_eq("long_unlock_ls", 64'(ls_at_unl), 64'd1);
    check_eq("long_err", 64'(err), 64'd1);
    check_eq("long_locked", 64'(locked), 64'd0);
    drive_frame(0, 5, -1, -1, -1);
    @(negedge clk);
    check_eq("relock_1vs", 64'(locked), 64'd0);
    drive_frame(0, 5, -1, -1, -1);
    @(negedge clk);
    check_eq("relock_2vs", 64'(locked), 64'd1);

    drive_frame(0, 6, -1, -1, -1);
    drive_frame(0, 5, -1, -1, 0);
    @(negedge clk);
    check_eq("frame_unlock_cyc", 64'(unlock_cyc), 64'(mark_cyc + 2));
    check_eq("frame_unlock_fs", 64'(fs_at_unl), 64'd1);
    check_eq("frame_err", 64'(err), 64'd3);
    check_eq("frame_locked", 64'(locked), 64'd0);

    drive_frame(0, 5, -1, 2, -1);
    @(negedge clk);
    check_eq("width_err", 64'(err), 64'd7);
    drive_frame(0, 2, -1, -1, -1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_err", 64'(err), 64'd0);
    check_eq("midrst_locked", 64'(locked), 64'd0);
    check_eq("midrst_valid", 64'(pixel_valid), 64'd0);

    drive_frame(3, 5, -1, -1, -1);
    drive_frame(0, 5, -1, -1, -1);
    @(negedge clk);
    check_eq("postrst_1vs", 64'(locked), 64'd0);
    pix_one = 1'b1;
    drive_frame(0, 5, -1, -1, -1);
    pix_one = 1'b0;
    @(negedge clk);
    check_eq("postrst_2vs", 64'(locked), 64'd1);
    drive_frame(0, 5, -1, -1, -1);
    @(negedge clk);
`ifdef VGA_DEC_SUM_EN
    check_eq("frame_sum", 64'(frame_sum), 64'd32);
`else
    check_eq("frame_sum", 64'(frame_sum), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
